// File: rtl/gpu_pkg.sv
// gpu_pkg: shared cluster window size and scheduler FSM encoding.
package gpu_pkg;
  localparam int CLUSTER_ADDR_SIZE = 4192;
  typedef enum logic [1:0] {IDLE, DECODE, ISSUE} sched_state_e;
endpackage

// File: rtl/gpu_write_scheduler_if.sv
// gpu_write_scheduler_if: write ingress from axil_controller and strobe egress to the cluster array.
interface gpu_write_scheduler_if #(
  parameter int ADDR_WIDTH       = 24,
  parameter int DATA_WIDTH       = 32,
  parameter int CLUSTER_COUNT    = 5,
  parameter int LOCAL_ADDR_WIDTH = 16,
  parameter int CDATA_WIDTH      = 16,
  parameter int FIFO_DEPTH       = 16
);
  logic [ADDR_WIDTH-1:0]          in_waddr;
  logic [DATA_WIDTH-1:0]          in_wdata;
  logic                           in_wen;
  logic                           in_ready;
  logic                           defer;
  logic                           vblank;
  logic [LOCAL_ADDR_WIDTH-1:0]    cluster_waddr;
  logic [CDATA_WIDTH-1:0]         cluster_wdata;
  logic [CLUSTER_COUNT-1:0]       cluster_wen;
  logic [$clog2(FIFO_DEPTH):0]    pending;
  logic                           overflow;
  logic [7:0]                     err_count;
  modport master (
    output in_waddr, in_wdata, in_wen, defer, vblank,
    input  in_ready, cluster_waddr, cluster_wdata, cluster_wen, pending, overflow, err_count
  );
  modport slave (
    input  in_waddr, in_wdata, in_wen, defer, vblank,
    output in_ready, cluster_waddr, cluster_wdata, cluster_wen, pending, overflow, err_count
  );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered occupancy count and first-word-fall-through head.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;
  assign full    = cnt_q == (AW+1)'(DEPTH);
  assign empty   = cnt_q == '0;
  assign count   = cnt_q;
  assign dout    = mem_q[rd_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/gpu_write_scheduler.sv
// gpu_write_scheduler: buffers writes, decodes cluster/offset by repeated subtraction, issues one-hot strobes.
module gpu_write_scheduler
  import gpu_pkg::*;
#(
  parameter int ADDR_WIDTH       = 24,
  parameter int DATA_WIDTH       = 32,
  parameter int CLUSTER_COUNT    = 5,
  parameter int LOCAL_ADDR_WIDTH = 16,
  parameter int CDATA_WIDTH      = 16,
  parameter int FIFO_DEPTH       = 16
) (
  input logic                  clk,
  input logic                  rst,
  gpu_write_scheduler_if.slave bus
);
  localparam int LW = LOCAL_ADDR_WIDTH;
  localparam int DW = CDATA_WIDTH;
  localparam int IW = (CLUSTER_COUNT > 1) ? $clog2(CLUSTER_COUNT) : 1;
  localparam logic [LW-1:0] WIN = LW'(CLUSTER_ADDR_SIZE);
  localparam logic [IW-1:0] LAST = IW'(CLUSTER_COUNT - 1);
  sched_state_e             state_q, state_d;
  logic [LW-1:0]            rem_q, rem_d, waddr_q, waddr_d, head_addr;
  logic [DW-1:0]            data_q, data_d, wdata_q, wdata_d, head_data;
  logic [IW-1:0]            idx_q, idx_d;
  logic [CLUSTER_COUNT-1:0] wen_q, wen_d;
  logic [7:0]               err_q, err_d;
  logic                     ovf_q, ovf_d;
  logic                     full, empty, push, pop, gate_open;
  logic                     unused_bits;
  assign unused_bits = ^{bus.in_waddr[ADDR_WIDTH-1:LW+2], bus.in_waddr[1:0], bus.in_wdata[DATA_WIDTH-1:DW]};
  assign push      = bus.in_wen && !full;
  assign gate_open = !bus.defer || bus.vblank;
  sync_fifo #(.WIDTH(LW + DW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   ({bus.in_waddr[LW+1:2], bus.in_wdata[DW-1:0]}),
    .dout  ({head_addr, head_data}),
    .full  (full),
    .empty (empty),
    .count (bus.pending)
  );
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    data_d  = data_q;
    idx_d   = idx_q;
    wen_d   = '0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    pop     = 1'b0;
    ovf_d   = ovf_q || (bus.in_wen && full);
    case (state_q)
      IDLE: if (!empty && gate_open) begin
        pop     = 1'b1;
        rem_d   = head_addr;
        data_d  = head_data;
        idx_d   = '0;
        state_d = DECODE;
      end
      DECODE: if (rem_q < WIN) begin
        wen_d   = CLUSTER_COUNT'(1) << idx_q;
        waddr_d = rem_q;
        wdata_d = data_q;
        state_d = ISSUE;
      end else if (idx_q == LAST) begin
        err_d   = err_q + 8'(err_q != 8'hFF);
        state_d = IDLE;
      end else begin
        rem_d = rem_q - WIN;
        idx_d = idx_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      data_q  <= '0;
      idx_q   <= '0;
      wen_q   <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      err_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
    end
  end
  assign bus.in_ready      = !full;
  assign bus.cluster_wen   = wen_q;
  assign bus.cluster_waddr = waddr_q;
  assign bus.cluster_wdata = wdata_q;
  assign bus.err_count     = err_q;
  assign bus.overflow      = ovf_q;
endmodule
